// File: rtl/instr_loader_pkg.sv
// Shared constants for the serial instruction loader: state encodings,
// the default frame header and the frame length decoder.
package instr_loader_pkg;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    // Loader frame FSM states
    localparam logic [2:0] LD_IDLE  = 3'd0;
    localparam logic [2:0] LD_LEN   = 3'd1;
    localparam logic [2:0] LD_DATA  = 3'd2;
    localparam logic [2:0] LD_CHECK = 3'd3;
    localparam logic [2:0] LD_DONE  = 3'd4;
    localparam logic [2:0] LD_ERROR = 3'd5;

    // UART receiver states
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // LEN byte 0 encodes 256; the count never exceeds the memory depth.
    function automatic logic [8:0] frame_len(input logic [7:0] len_byte,
                                             input int unsigned depth);
        logic [8:0] len;
        len = (len_byte == 8'd0) ? 9'd256 : {1'b0, len_byte};
        if (32'(len) > depth) begin
            len = 9'(depth);
        end
        return len;
    endfunction

endpackage

// File: rtl/instr_loader_uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling on an already-synchronized
// line. Emits a one-cycle byte_valid or frame_err right after the stop sample.
module instr_loader_uart_rx
    import instr_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx_sync,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullM1 = CntW'(CLKS_PER_BIT - 1);

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      byte_q, byte_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    // Bit timing and shift register next-state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_sync) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HalfM1) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    // Line back high at mid-start: a glitch, not a start bit
                    state_d = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FullM1) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FullM1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_sync) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Receiver state registers with synchronous reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            byte_q  <= 8'd0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_byte    = byte_q;
    assign byte_valid = valid_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/instr_loader.sv
// Serial boot loader: receives HEADER, LEN, data, CSUM over UART, writes the
// data into instruction memory and releases the CPU only on a valid image.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned ADDR_W       = 8,
    parameter logic [7:0]  HEADER       = HEADER_DEFAULT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rx,
    output logic [ADDR_W-1:0] im_addr,
    output logic [7:0]        im_w_data,
    output logic              im_w_en,
    output logic              cpu_reset_n,
    output logic              busy,
    output logic              error
);

    localparam int unsigned MemDepth = 1 << ADDR_W;

    logic [1:0]        sync_q, sync_d;
    logic              rx_sync;
    logic [7:0]        rx_byte;
    logic              byte_valid;
    logic              frame_err;

    logic [2:0]        state_q, state_d;
    logic [8:0]        remain_q, remain_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        sum_q, sum_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [7:0]        im_w_data_q, im_w_data_d;
    logic              im_w_en_q, im_w_en_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;

    // Two-flop synchronizer for the asynchronous rx line
    always_comb begin
        sync_d = {sync_q[0], rx};
    end

    assign rx_sync = sync_q[1];

    instr_loader_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock     (clock),
        .reset_n   (reset_n),
        .rx_sync   (rx_sync),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    // Frame FSM, address counter and checksum accumulator
    always_comb begin
        state_d     = state_q;
        remain_d    = remain_q;
        addr_d      = addr_q;
        sum_d       = sum_q;
        im_addr_d   = im_addr_q;
        im_w_data_d = im_w_data_q;
        im_w_en_d   = 1'b0;
        cpu_rst_n_d = cpu_rst_n_q;
        busy_d      = busy_q;
        error_d     = error_q;
        if (frame_err) begin
            if (state_q == LD_LEN || state_q == LD_DATA || state_q == LD_CHECK) begin
                state_d     = LD_ERROR;
                busy_d      = 1'b0;
                error_d     = 1'b1;
                cpu_rst_n_d = 1'b0;
            end
        end else if (byte_valid) begin
            case (state_q)
                LD_IDLE, LD_DONE, LD_ERROR: begin
                    if (rx_byte == HEADER) begin
                        state_d     = LD_LEN;
                        busy_d      = 1'b1;
                        error_d     = 1'b0;
                        cpu_rst_n_d = 1'b0;
                    end
                end
                LD_LEN: begin
                    remain_d = frame_len(rx_byte, MemDepth);
                    sum_d    = 8'd0;
                    addr_d   = '0;
                    state_d  = LD_DATA;
                end
                LD_DATA: begin
                    im_w_en_d   = 1'b1;
                    im_addr_d   = addr_q;
                    im_w_data_d = rx_byte;
                    sum_d       = sum_q + rx_byte;
                    addr_d      = addr_q + 1'b1;
                    remain_d    = remain_q - 9'd1;
                    if (remain_q == 9'd1) begin
                        state_d = LD_CHECK;
                    end
                end
                LD_CHECK: begin
                    busy_d = 1'b0;
                    if (rx_byte == sum_q) begin
                        state_d     = LD_DONE;
                        cpu_rst_n_d = 1'b1;
                    end else begin
                        state_d = LD_ERROR;
                        error_d = 1'b1;
                    end
                end
                default: state_d = LD_IDLE;
            endcase
        end
    end

    // Loader registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_q      <= 2'b11;
            state_q     <= LD_IDLE;
            remain_q    <= 9'd0;
            addr_q      <= '0;
            sum_q       <= 8'd0;
            im_addr_q   <= '0;
            im_w_data_q <= 8'd0;
            im_w_en_q   <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            remain_q    <= remain_d;
            addr_q      <= addr_d;
            sum_q       <= sum_d;
            im_addr_q   <= im_addr_d;
            im_w_data_q <= im_w_data_d;
            im_w_en_q   <= im_w_en_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
        end
    end

    assign im_addr     = im_addr_q;
    assign im_w_data   = im_w_data_q;
    assign im_w_en     = im_w_en_q;
    assign cpu_reset_n = cpu_rst_n_q;
    assign busy        = busy_q;
    assign error       = error_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: table of framed byte sequences, hand-written corner
// sequences and random frames, all checked against a frame-level model.
module tb_instr_loader;

    localparam int CPB = 8;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] im_addr;
    logic [7:0] im_w_data;
    logic       im_w_en;
    logic       cpu_reset_n;
    logic       busy;
    logic       error;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t obs_q[$];
    wr_t exp_q[$];

    // Frame-level reference model state
    bit         m_in_frame;
    bit         m_have_len;
    int         m_need;
    logic [7:0] m_data[$];
    bit         m_busy, m_err, m_cpu;

    typedef struct {
        int         n;
        logic [7:0] b[8];
        int         bad;
        logic       e_cpu;
        logic       e_busy;
        logic       e_err;
    } vec_t;

    vec_t vecs[8];

    always #5 clock = ~clock;

    instr_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (8),
        .HEADER      (8'hA5)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rx         (rx),
        .im_addr    (im_addr),
        .im_w_data  (im_w_data),
        .im_w_en    (im_w_en),
        .cpu_reset_n(cpu_reset_n),
        .busy       (busy),
        .error      (error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 0;
        m_have_len = 0;
        m_need     = 0;
        m_data.delete();
        m_busy     = 0;
        m_err      = 0;
        m_cpu      = 0;
    endtask

    // One received UART event: a good byte (ok=1) or a stop-bit error (ok=0)
    task automatic model_byte(input logic [7:0] b, input bit ok);
        int s;
        if (!ok) begin
            if (m_in_frame) begin
                m_in_frame = 0;
                m_busy     = 0;
                m_err      = 1;
                m_cpu      = 0;
            end
        end else if (!m_in_frame) begin
            if (b == 8'hA5) begin
                m_in_frame = 1;
                m_have_len = 0;
                m_busy     = 1;
                m_err      = 0;
                m_cpu      = 0;
            end
        end else if (!m_have_len) begin
            m_have_len = 1;
            m_need     = (b == 8'd0) ? 256 : int'(b);
            m_data.delete();
        end else if (m_data.size() < m_need) begin
            m_data.push_back(b);
            exp_q.push_back({8'(m_data.size() - 1), b});
        end else begin
            s = 0;
            foreach (m_data[i]) s += int'(m_data[i]);
            m_in_frame = 0;
            m_busy     = 0;
            if (8'(s) == b) m_cpu = 1;
            else m_err = 1;
        end
    endtask

    // Serialise one byte, LSB first, then hold the line idle for gap cycles
    task automatic send_byte(input logic [7:0] b, input bit stop, input int gap);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            repeat (CPB) @(negedge clock);
        end
        rx = 1'b1;
        repeat (gap) @(negedge clock);
    endtask

    task automatic send_ev(input logic [7:0] b, input bit ok, input int gap);
        send_byte(b, ok, gap);
        model_byte(b, ok);
    endtask

    task automatic compare(input string name, input logic e_cpu, input logic e_busy,
                           input logic e_err);
        repeat (2) @(posedge clock);
        #2;
        check({name, ".cpu_reset_n"}, cpu_reset_n, e_cpu);
        check({name, ".busy"}, busy, e_busy);
        check({name, ".error"}, error, e_err);
        check({name, ".n_writes"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s.write%0d", name, i), obs_q[i], exp_q[i]);
        end
        obs_q.delete();
        exp_q.delete();
        @(negedge clock);
    endtask

    // Write capture and cross-cycle relations between strobe, busy and cpu reset
    logic prev_busy = 1'b0;
    logic prev_cpu  = 1'b0;
    logic prev_wen  = 1'b0;
    always @(posedge clock) begin
        #2;
        if (prev_wen) check("wen_one_cycle", im_w_en, 1'b0);
        if (reset_n && !prev_busy && busy) check("cpu_low_on_busy_rise", cpu_reset_n, 1'b0);
        if (reset_n && prev_busy && !busy && !error)
            check("cpu_release_with_busy_fall", {prev_cpu, cpu_reset_n}, 2'b01);
        if (im_w_en === 1'b1) obs_q.push_back({im_addr, im_w_data});
        prev_busy = busy;
        prev_cpu  = cpu_reset_n;
        prev_wen  = im_w_en;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d[$];
        int         len, kind, bad_at, s;

        vecs[0] = '{6, '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66, 8'h00, 8'h00}, -1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{5, '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00}, -1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{4, '{8'hA5, 8'h01, 8'h44, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00}, -1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{4, '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00},  3, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{6, '{8'h7E, 8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00}, -1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{4, '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, -1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{3, '{8'hA5, 8'h02, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, -1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{2, '{8'h07, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, -1, 1'b1, 1'b0, 1'b0};

        model_reset();
        repeat (3) @(negedge clock);
        @(posedge clock);
        #2;
        check("reset.im_addr", im_addr, 8'h00);
        check("reset.im_w_data", im_w_data, 8'h00);
        check("reset.im_w_en", im_w_en, 1'b0);
        check("reset.cpu_reset_n", cpu_reset_n, 1'b0);
        check("reset.busy", busy, 1'b0);
        check("reset.error", error, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < vecs[i].n; j++) begin
                send_ev(vecs[i].b[j], j != vecs[i].bad, (j == vecs[i].bad) ? 2 * CPB : 4);
            end
            if (i == 6) repeat (300) @(negedge clock);
            compare($sformatf("vec%0d", i), vecs[i].e_cpu, vecs[i].e_busy, vecs[i].e_err);
        end

        // Short low glitch on an idle line must not start a byte
        rx = 1'b0;
        repeat (3) @(negedge clock);
        rx = 1'b1;
        repeat (4 * CPB) @(negedge clock);
        compare("glitch", 1'b1, 1'b0, 1'b0);

        // Reset in the middle of the data phase
        send_ev(8'hA5, 1, 4);
        send_ev(8'h04, 1, 4);
        send_ev(8'h01, 1, 4);
        send_ev(8'h02, 1, 4);
        compare("pre_reset", 1'b0, 1'b1, 1'b0);
        reset_n = 1'b0;
        @(posedge clock);
        #2;
        check("midreset.im_addr", im_addr, 8'h00);
        check("midreset.im_w_data", im_w_data, 8'h00);
        check("midreset.im_w_en", im_w_en, 1'b0);
        check("midreset.cpu_reset_n", cpu_reset_n, 1'b0);
        check("midreset.busy", busy, 1'b0);
        check("midreset.error", error, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clock);
        send_ev(8'hA5, 1, 4);
        send_ev(8'h02, 1, 4);
        send_ev(8'hAA, 1, 4);
        send_ev(8'hBB, 1, 4);
        send_ev(8'h65, 1, 4);
        compare("post_reset", 1'b1, 1'b0, 1'b0);

        // LEN=0 loads 256 bytes, the last at address 255
        s = 0;
        send_ev(8'hA5, 1, 2);
        send_ev(8'h00, 1, 2);
        for (int i = 0; i < 256; i++) begin
            send_ev(8'(i * 3 + 1), 1, 1);
            s += (i * 3 + 1) & 255;
        end
        check("len0.last_addr", (obs_q.size() > 0) ? obs_q[obs_q.size() - 1].a : 8'h00, 8'hFF);
        send_ev(8'(s), 1, 4);
        compare("len0", 1'b1, 1'b0, 1'b0);

        // Random frames: mostly valid, some with bad checksum, stop error or junk
        for (int f = 0; f < 12; f++) begin
            len    = int'($urandom_range(1, 6));
            kind   = int'($urandom_range(0, 9));
            bad_at = int'($urandom_range(0, len - 1));
            d.delete();
            s = 0;
            for (int i = 0; i < len; i++) begin
                d.push_back(8'($urandom));
                s += int'(d[i]);
            end
            if (kind == 2) send_ev(8'($urandom_range(0, 8'hA4)), 1, 3);
            send_ev(8'hA5, 1, int'($urandom_range(1, 20)));
            send_ev(8'(len), 1, int'($urandom_range(1, 20)));
            for (int i = 0; i < len; i++) begin
                if (kind == 1 && i == bad_at) begin
                    send_ev(d[i], 0, 2 * CPB);
                    break;
                end
                send_ev(d[i], 1, int'($urandom_range(1, 20)));
            end
            if (kind != 1) send_ev((kind == 0) ? 8'(s + 1) : 8'(s), 1, 4);
            compare($sformatf("rand%0d", f), m_cpu, m_busy, m_err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
